n_term_wire_probe: RTL and testbench



---
 rtl/n_term_wire_probe.sv | 106 ++++++++++
 tb/tb_n_term_wire_probe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/n_term_wire_probe.sv
// rtl/n_term_wire_probe.sv - north terminal wire snapshot, masked compare and serial readout
module n_term_wire_probe #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 16
) (
  input  logic             UserCLK,
  input  logic             resetn,
  input  logic [WIDTH-1:0] from_N_bus,
  input  logic [WIDTH-1:0] exp_pattern,
  input  logic [WIDTH-1:0] cmp_mask,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             sout_data,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             done,
  output logic [6:0]       diff_bits,
  output logic [CNT_W-1:0] fail_cnt,
  input  logic             clr_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] snap;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             cnt_pend;
  logic [WIDTH-1:0] mism;
  logic [6:0]       pop;

  assign mism    = (from_N_bus ^ exp_pattern) & cmp_mask;
  assign idx_nxt = idx + IDX_W'(1);

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + {6'd0, mism[i]};
    end
  end

  // sout_data is registered: loaded with bit 0 at accept, then the next bit on each handshake.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state       <= IDLE;
      snap        <= '0;
      idx         <= '0;
      cnt_pend    <= 1'b0;
      start_ready <= 1'b1;
      sout_valid  <= 1'b0;
      sout_data   <= 1'b0;
      done        <= 1'b0;
      diff_bits   <= '0;
      fail_cnt    <= '0;
    end else begin
      done     <= 1'b0;
      cnt_pend <= 1'b0;

      // Increment lands one edge after diff_bits becomes visible; clear has priority.
      if (clr_cnt) begin
        fail_cnt <= '0;
      end else if (cnt_pend && (fail_cnt != {CNT_W{1'b1}})) begin
        fail_cnt <= fail_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start_valid) begin
            snap        <= from_N_bus;
            diff_bits   <= pop;
            cnt_pend    <= (pop != 7'd0);
            idx         <= '0;
            sout_data   <= from_N_bus[0];
            sout_valid  <= 1'b1;
            start_ready <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            if (idx == LAST_IDX) begin
              sout_valid  <= 1'b0;
              sout_data   <= 1'b0;
              start_ready <= 1'b1;
              done        <= 1'b1;
              idx         <= '0;
              state       <= IDLE;
            end else begin
              idx       <= idx_nxt;
              sout_data <= snap[idx_nxt];
            end
          end
        end
        default: begin
          state       <= IDLE;
          sout_valid  <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n_term_wire_probe.sv
// tb/tb_n_term_wire_probe.sv - directed bench for n_term_wire_probe
module tb_n_term_wire_probe;

  logic        UserCLK = 1'b0;
  logic        resetn;
  logic [47:0] from_N_bus;
  logic [47:0] exp_pattern;
  logic [47:0] cmp_mask;
  logic        start_valid;
  logic        start_ready;
  logic        sout_data;
  logic        sout_valid;
  logic        sout_ready;
  logic        done;
  logic [6:0]  diff_bits;
  logic [15:0] fail_cnt;
  logic        clr_cnt;

  logic        start_ready2;
  logic        sout_data2;
  logic        sout_valid2;
  logic        done2;
  logic [6:0]  diff_bits2;
  logic [1:0]  fail_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 UserCLK = ~UserCLK;

  n_term_wire_probe #(.WIDTH(48), .CNT_W(16)) dut (
    .UserCLK(UserCLK), .resetn(resetn), .from_N_bus(from_N_bus),
    .exp_pattern(exp_pattern), .cmp_mask(cmp_mask), .start_valid(start_valid),
    .start_ready(start_ready), .sout_data(sout_data), .sout_valid(sout_valid),
    .sout_ready(sout_ready), .done(done), .diff_bits(diff_bits),
    .fail_cnt(fail_cnt), .clr_cnt(clr_cnt)
  );

  // Narrow counter instance so saturation is reachable in a few captures.
  n_term_wire_probe #(.WIDTH(48), .CNT_W(2)) dut_sat (
    .UserCLK(UserCLK), .resetn(resetn), .from_N_bus(from_N_bus),
    .exp_pattern(exp_pattern), .cmp_mask(cmp_mask), .start_valid(start_valid),
    .start_ready(start_ready2), .sout_data(sout_data2), .sout_valid(sout_valid2),
    .sout_ready(sout_ready), .done(done2), .diff_bits(diff_bits2),
    .fail_cnt(fail_cnt2), .clr_cnt(clr_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // mode 0: sout_ready held high; mode 1: sout_ready random 50%.
  task automatic capture(input string tag, input logic [47:0] pat, input logic [47:0] expv,
                         input logic [47:0] mask, input int mode, input bit disturb,
                         input bit clr1, input logic [6:0] exp_diff, input logic [15:0] exp_cnt);
    logic [47:0] got;
    int nbits, cyc, stall_err, overlap_err;
    bit prev_stall, rdy;
    logic prev_data;
    from_N_bus  = pat;
    exp_pattern = expv;
    cmp_mask    = mask;
    start_valid = 1'b1;
    sout_ready  = 1'b1;
    @(negedge UserCLK);
    start_valid = 1'b0;
    cyc = 1;
    check({tag, "_valid_t1"}, 64'(sout_valid), 64'd1);
    check({tag, "_diff_t1"}, 64'(diff_bits), 64'(exp_diff));
    got = '0; nbits = 0; stall_err = 0; overlap_err = 0; prev_stall = 0; prev_data = 1'b0;
    while (nbits < 48 && cyc < 400) begin
      if (prev_stall && (sout_data !== prev_data)) stall_err++;
      if (done && sout_valid) overlap_err++;
      if (cyc == 2) check({tag, "_cnt_t2"}, 64'(fail_cnt), 64'(exp_cnt));
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      sout_ready  = rdy;
      clr_cnt     = (clr1 && cyc == 1);
      start_valid = (disturb && cyc == 5);
      if (disturb && cyc == 5) begin
        from_N_bus  = ~pat;
        exp_pattern = ~expv;
        cmp_mask    = ~mask;
      end
      if (sout_valid && rdy) begin
        got[nbits] = sout_data;
        nbits++;
      end
      prev_stall = sout_valid && !rdy;
      prev_data  = sout_data;
      @(negedge UserCLK);
      cyc++;
    end
    clr_cnt     = 1'b0;
    start_valid = 1'b0;
    check({tag, "_stream"}, 64'(got), 64'(pat));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_valid_end"}, 64'(sout_valid), 64'd0);
    check({tag, "_ready_end"}, 64'(start_ready), 64'd1);
    check({tag, "_diff_end"}, 64'(diff_bits), 64'(exp_diff));
    check({tag, "_cnt_end"}, 64'(fail_cnt), 64'(exp_cnt));
    if (mode == 0) check({tag, "_latency"}, 64'(cyc), 64'd49);
    if (mode != 0) check({tag, "_stall_stable"}, 64'(stall_err), 64'd0);
    check({tag, "_done_overlap"}, 64'(overlap_err), 64'd0);
    @(negedge UserCLK);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  localparam logic [47:0] P0   = 48'hA5A5_0F0F_3C3C;
  localparam logic [47:0] FLIP = 48'h8000_0000_2001;
  localparam logic [47:0] M13  = ~48'h0000_0000_2000;
  localparam logic [47:0] ONES = '1;

  initial begin
    int bad;
    resetn = 1'b0; from_N_bus = '0; exp_pattern = '0; cmp_mask = '0;
    start_valid = 1'b0; sout_ready = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(negedge UserCLK);
    resetn = 1'b1;
    @(negedge UserCLK);
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_sout_valid", 64'(sout_valid), 64'd0);
    check("rst_sout_data", 64'(sout_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_diff", 64'(diff_bits), 64'd0);
    check("rst_fail_cnt", 64'(fail_cnt), 64'd0);

    bad = 0;
    from_N_bus = 48'hFFFF_0000_FFFF;
    repeat (20) begin
      @(negedge UserCLK);
      if (start_ready !== 1'b1 || sout_valid !== 1'b0 || done !== 1'b0 ||
          sout_data !== 1'b0 || diff_bits !== 7'd0 || fail_cnt !== 16'd0) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);

    capture("pass", P0, P0, ONES, 0, 0, 0, 7'd0, 16'd0);
    capture("fail1", P0, P0 ^ FLIP, M13, 0, 0, 0, 7'd2, 16'd1);
    capture("fail2", P0, P0 ^ FLIP, M13, 0, 0, 0, 7'd2, 16'd2);
    capture("fail3", P0, P0 ^ FLIP, M13, 0, 0, 0, 7'd2, 16'd3);
    capture("fail4", P0, P0 ^ FLIP, M13, 0, 0, 0, 7'd2, 16'd4);
    check("sat_cnt", 64'(fail_cnt2), 64'd3);
    capture("fail5", P0, P0 ^ FLIP, M13, 0, 0, 0, 7'd2, 16'd5);
    check("sat_hold", 64'(fail_cnt2), 64'd3);

    capture("stall", 48'h1234_5678_9ABC, 48'h1234_5678_9ABC, ONES, 1, 1, 0, 7'd0, 16'd5);
    capture("stall2", 48'hDEAD_BEEF_0F1E, 48'hDEAD_BEEF_0F1F, ONES, 1, 1, 0, 7'd1, 16'd6);

    capture("clr", P0, P0 ^ FLIP, ONES, 0, 0, 1, 7'd3, 16'd0);

    // Abort a stream with reset while bit 20 is presented.
    from_N_bus = 48'h0F0F_F0F0_5555; exp_pattern = 48'h0F0F_F0F0_5554; cmp_mask = ONES;
    start_valid = 1'b1; sout_ready = 1'b1;
    @(negedge UserCLK);
    start_valid = 1'b0;
    repeat (20) @(negedge UserCLK);
    check("abort_pre_valid", 64'(sout_valid), 64'd1);
    check("abort_pre_data", 64'(sout_data), 64'(from_N_bus[20]));
    check("abort_pre_cnt", 64'(fail_cnt), 64'd1);
    resetn = 1'b0;
    @(negedge UserCLK);
    resetn = 1'b1;
    check("abort_valid", 64'(sout_valid), 64'd0);
    check("abort_ready", 64'(start_ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_cnt", 64'(fail_cnt), 64'd0);
    check("abort_diff", 64'(diff_bits), 64'd0);
    bad = 0;
    repeat (5) begin
      @(negedge UserCLK);
      if (done !== 1'b0 || sout_valid !== 1'b0) bad++;
    end
    check("abort_no_done", 64'(bad), 64'd0);

    capture("fresh", 48'h0123_4567_89AB, 48'h0123_4567_89AB, ONES, 0, 0, 0, 7'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
